// File: rtl/ymat_pkg.sv
// Shared definitions for the Y-matrix row-pointer table.
// The writer and the address-lookup reader both take the slot layout from here,
// so there is only one definition of where slot k lives in a word.
package ymat_pkg;

  localparam int PTR_W      = 10;
  localparam int SLOT_W     = 16;
  localparam int SLOTS      = 16;
  localparam int WORD_W     = SLOT_W * SLOTS;
  localparam int ADDR_W     = 11;
  localparam int SLOT_IDX_W = $clog2(SLOTS);
  localparam int PAD_W      = SLOT_W - PTR_W;

  // Writer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bit position of the LSB of slot k.
  // Slot 0 sits at the top of the word, slot SLOTS-1 at the bottom.
  function automatic int unsigned slot_lsb(input logic [SLOT_IDX_W-1:0] k);
    int unsigned k_int;
    k_int = int'({1'b0, k});
    return SLOT_W * (SLOTS - 1 - k_int);
  endfunction

endpackage

// File: rtl/ymat_slot_packer.sv
// Word assembly buffer for the row-pointer writer.
// It holds one SRAM word and a slot index. A load zero-extends the pointer into
// the current slot and advances the index. A clear empties the whole word.
// Clear wins over load. The two never coincide in normal use, but the priority
// keeps the buffer well defined if they do.
module ymat_slot_packer
  import ymat_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [PTR_W-1:0]      ptr,
  output logic [WORD_W-1:0]     data,
  output logic [SLOT_IDX_W-1:0] slot,
  output logic                  last_slot
);

  logic [WORD_W-1:0]     buf_q, buf_d;
  logic [SLOT_IDX_W-1:0] slot_q, slot_d;

  // Next-state logic: clear, or insert into the current slot and advance.
  always_comb begin
    buf_d  = buf_q;
    slot_d = slot_q;
    if (clear) begin
      buf_d  = '0;
      slot_d = '0;
    end else if (load) begin
      buf_d[slot_lsb(slot_q) +: SLOT_W] = {{PAD_W{1'b0}}, ptr};
      // Slot index wraps naturally at SLOTS (a power of two).
      slot_d = slot_q + 1'b1;
    end
  end

  // Buffer and slot index registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_q  <= '0;
      slot_q <= '0;
    end else begin
      buf_q  <= buf_d;
      slot_q <= slot_d;
    end
  end

  assign data      = buf_q;
  assign slot      = slot_q;
  assign last_slot = (slot_q == SLOT_IDX_W'(SLOTS - 1));

endmodule

// File: rtl/ymat_ptr_pack_writer.sv
// Write side of the Y-matrix row-pointer table.
// Packs 10-bit row start addresses, 16 per 256-bit word, and issues one SRAM
// write per word through the shared arbiter.
//
// Handshakes:
//   Entry input: an entry transfers on a rising edge where in_valid && in_ready.
//   in_ready depends only on state. in_valid while in_ready=0 has no effect.
//   SRAM write: sram_wr_req stays high with addr/data stable until the edge
//   where sram_wr_req && sram_wr_gnt. The write commits on that edge.
module ymat_ptr_pack_writer
  import ymat_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PTR_W-1:0]  in_ptr,
  input  logic              in_last,
  output logic              sram_wr_req,
  input  logic              sram_wr_gnt,
  output logic [ADDR_W-1:0] sram_wr_addr,
  output logic [WORD_W-1:0] sram_wr_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       entry_count,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  // Set when the word being filled or written holds the table's last entry.
  logic              last_q, last_d;

  logic                  pk_clear;
  logic                  pk_load;
  logic [WORD_W-1:0]     pk_data;
  logic [SLOT_IDX_W-1:0] pk_slot;
  logic                  pk_last_slot;

  ymat_slot_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (pk_clear),
    .load      (pk_load),
    .ptr       (in_ptr),
    .data      (pk_data),
    .slot      (pk_slot),
    .last_slot (pk_last_slot)
  );

  // FSM next state, address/count updates and packer control.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    last_d   = last_q;
    pk_clear = 1'b0;
    pk_load  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = start_addr;
          count_d  = '0;
          last_d   = 1'b0;
          pk_clear = 1'b1;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (in_valid) begin
          pk_load = 1'b1;
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
          last_d = in_last;
          // A 16th entry that is also last still produces exactly one word.
          if (pk_last_slot || in_last) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (sram_wr_gnt) begin
          // The address wraps from 2^ADDR_W-1 to 0 by truncation.
          addr_d   = addr_q + 1'b1;
          pk_clear = 1'b1;
          state_d  = last_q ? ST_DONE : ST_FILL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, address, count and last-flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  // Outputs are decoded from registered state only.
  // As a result, reset drops sram_wr_req without waiting for a clock edge.
  assign in_ready     = (state_q == ST_FILL);
  assign sram_wr_req  = (state_q == ST_WRITE);
  assign sram_wr_addr = addr_q;
  assign sram_wr_data = pk_data;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign entry_count  = count_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ymat_ptr_pack_writer.sv
// Bench for ymat_ptr_pack_writer.
// Expected SRAM writes come from a table-level model and go into a queue.
// A monitor pops and compares them on every granted request.
module tb_ymat_ptr_pack_writer;
  import ymat_pkg::*;

  localparam int EW = ADDR_W + WORD_W;

  // ---------------- clock / reset ----------------
  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PTR_W-1:0]  in_ptr = '0;
  logic              in_last = 1'b0;
  logic              sram_wr_req;
  logic              sram_wr_gnt = 1'b0;
  logic [ADDR_W-1:0] sram_wr_addr;
  logic [WORD_W-1:0] sram_wr_data;
  logic              busy;
  logic              done;
  logic [15:0]       entry_count;
  state_e            dbg_state;

  always #5 clock = ~clock;

  ymat_ptr_pack_writer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .start_addr   (start_addr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ptr       (in_ptr),
    .in_last      (in_last),
    .sram_wr_req  (sram_wr_req),
    .sram_wr_gnt  (sram_wr_gnt),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .busy         (busy),
    .done         (done),
    .entry_count  (entry_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0]    exp_q[$];
  logic [PTR_W-1:0] tbl_q[$];
  int  gnt_mode = 0;   // 0 always, 1 random, 2 after 5 waits, 3 never
  int  req_run = 0;
  int  done_seen = 0;
  int  exp_done = 0;
  bit  granted_prev = 1'b0;
  bit  done_prev = 1'b0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Entry n lands in word base+n/16, slot n%16.
  // Slot k covers bits 16*(15-k) upward; its pad bits are zero.
  task automatic push_expected(input logic [ADDR_W-1:0] base, input bit has_last);
    int n;
    int nwords;
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] a;
    n = tbl_q.size();
    nwords = has_last ? (n + 15) / 16 : n / 16;
    for (int w = 0; w < nwords; w++) begin
      word = '0;
      for (int k = 0; k < 16; k++) begin
        if (w * 16 + k < n) word[(15 - k) * 16 +: 16] = {6'b0, tbl_q[w * 16 + k]};
      end
      a = base + ADDR_W'(w);
      exp_q.push_back({a, word});
    end
  endtask

  // ---------------- grant driver ----------------
  always @(posedge clock) begin
    #1;
    if (sram_wr_req) req_run++;
    else req_run = 0;
    case (gnt_mode)
      0:       sram_wr_gnt = 1'b1;
      1:       sram_wr_gnt = 1'($urandom_range(0, 1));
      2:       sram_wr_gnt = (req_run >= 6);
      default: sram_wr_gnt = 1'b0;
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (sram_wr_req) begin
        check("ready_in_write", EW'(in_ready), EW'(0));
        check("req_after_grant", EW'(granted_prev), EW'(0));
        if (exp_q.size() == 0) begin
          check("unexpected_write", {sram_wr_addr, sram_wr_data}, '0);
          if (sram_wr_gnt) begin
            checks++;
            errors++;
            $display("FAIL extra_write: got addr %0h with empty expected queue", sram_wr_addr);
          end
        end else begin
          check("wr_word", {sram_wr_addr, sram_wr_data}, exp_q[0]);
          if (sram_wr_gnt) void'(exp_q.pop_front());
        end
      end
      granted_prev = sram_wr_req && sram_wr_gnt;
      if (done) begin
        done_seen++;
        check("busy_in_done", EW'(busy), EW'(1));
        check("done_width", EW'(done_prev), EW'(0));
      end
      done_prev = done;
    end else begin
      granted_prev = 1'b0;
      done_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [ADDR_W-1:0] a);
    start = 1'b1;
    start_addr = a;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [PTR_W-1:0] p, input bit l);
    int budget;
    in_valid = 1'b1;
    in_ptr = p;
    in_last = l;
    budget = 0;
    @(negedge clock);
    while (!in_ready && budget < 300) begin
      @(negedge clock);
      budget++;
    end
    if (!in_ready) check("accept_timeout", EW'(1), EW'(0));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_ptr = PTR_W'($urandom);
    in_last = 1'($urandom_range(0, 1));
    repeat ($urandom_range(0, 2)) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic run_table(input logic [ADDR_W-1:0] base, input bit has_last,
                           input int mode, input bit mid_start);
    int n;
    int budget;
    n = tbl_q.size();
    gnt_mode = mode;
    push_expected(base, has_last);
    if (has_last) exp_done++;
    pulse_start(base);
    for (int i = 0; i < n; i++) begin
      send(tbl_q[i], has_last && (i == n - 1));
      // This start pulse lands while the DUT is in FILL, so it must be ignored.
      if (mid_start && i == 4) pulse_start(base + 11'h155);
    end
    budget = 0;
    if (has_last) begin
      @(negedge clock);
      while (busy && budget < 300) begin
        @(negedge clock);
        budget++;
      end
      check("table_end", EW'(busy), EW'(0));
      check("done_count", EW'(done_seen), EW'(exp_done));
    end else begin
      while (exp_q.size() != 0 && budget < 300) begin
        @(negedge clock);
        budget++;
      end
      @(negedge clock);
      check("fill_ready", EW'(in_ready), EW'(1));
      check("fill_busy", EW'(busy), EW'(1));
    end
    check("queue_drained", EW'(exp_q.size()), EW'(0));
    check("entry_count", EW'(entry_count), EW'(n));
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   EW'(sram_wr_req), EW'(0));
    check({tag, "_busy"},  EW'(busy), EW'(0));
    check({tag, "_count"}, EW'(entry_count), EW'(0));
    check({tag, "_ready"}, EW'(in_ready), EW'(0));
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_reset_vals("reset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int budget;
    int n;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("por");
    check("por_done", EW'(done), EW'(0));
    check("por_addr", EW'(sram_wr_addr), EW'(0));
    check("por_data", EW'(sram_wr_data), EW'(0));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Test 1: one full word without last, gnt held high; DUT stays in FILL afterwards.
    tbl_q.delete();
    for (int i = 1; i <= 16; i++) tbl_q.push_back(PTR_W'(i));
    run_table(11'h010, 1'b0, 0, 1'b0);
    reset_dut();

    // Test 2: 17 entries, last on the 17th.
    tbl_q.delete();
    for (int i = 0; i < 17; i++) tbl_q.push_back(PTR_W'(10'h100 + i));
    run_table(11'h020, 1'b1, 0, 1'b0);

    // Test 3: lone last entry at the top address, then a table that wraps to 0.
    tbl_q.delete();
    tbl_q.push_back(10'h3FF);
    run_table(11'h7FF, 1'b1, 0, 1'b0);
    tbl_q.delete();
    for (int i = 0; i < 33; i++) tbl_q.push_back(PTR_W'($urandom));
    run_table(11'h7FF, 1'b1, 1, 1'b0);

    // Test 4: grant delayed five cycles; entries keep arriving during WRITE.
    tbl_q.delete();
    for (int i = 0; i < 20; i++) tbl_q.push_back(PTR_W'($urandom));
    run_table(11'h123, 1'b1, 2, 1'b0);

    // Test 5: reset while waiting for grant; the word is discarded.
    gnt_mode = 3;
    tbl_q.delete();
    for (int i = 0; i < 16; i++) tbl_q.push_back(PTR_W'($urandom));
    pulse_start(11'h055);
    for (int i = 0; i < 16; i++) send(tbl_q[i], 1'b0);
    budget = 0;
    @(negedge clock);
    while (!sram_wr_req && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    check("reached_write", EW'(sram_wr_req), EW'(1));
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    exp_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    tbl_q.delete();
    for (int i = 0; i < 5; i++) tbl_q.push_back(PTR_W'($urandom));
    run_table(11'h056, 1'b1, 0, 1'b0);

    // Test 6: start during FILL must not move the address.
    tbl_q.delete();
    for (int i = 0; i < 30; i++) tbl_q.push_back(PTR_W'($urandom));
    run_table(11'h300, 1'b1, 1, 1'b1);

    // Random tables.
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 48);
      tbl_q.delete();
      for (int i = 0; i < n; i++) tbl_q.push_back(PTR_W'($urandom));
      run_table(ADDR_W'($urandom), 1'b1, 1, 1'($urandom_range(0, 1)) && (n > 6));
    end

    check("final_queue", EW'(exp_q.size()), EW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
